// File: rtl/int_bit_manip_core.sv
// int_bit_manip_core
//   Registered 64-bit integer bit-manipulation unit. It clears, sets or reads
//   single bits of opa, loads opa, or shifts it (SLL/SRL/SRA). opb[5:0]
//   supplies the bit index or the shift amount. The active operand width N is
//   16, 32 or 64 bits, chosen by size_sel. Every result is zero-extended above
//   bit N-1. Results appear one cycle after an en edge.
//
//   Optional feature macro: INT_BIT_MANIP_POPCNT_EN
//     defined   : opcode 111 returns the population count of the operand.
//     undefined : opcode 111 is a legal no-op that returns 0.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous, active-high reset
//   en        in   1   capture/compute strobe
//   operation in   3   opcode
//   size_sel  in   2   00=16b, 01=32b, 1x=64b
//   opa       in   W   data operand
//   opb       in   W   bit index / shift amount (only [5:0] used)
//   out       out  W   registered result
//   valid     out  1   one-cycle pulse marking an updated result
//   zero      out  1   registered (out == 0)
module int_bit_manip_core #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [2:0]   operation,
   input  logic [1:0]   size_sel,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   output logic [W-1:0] out,
   output logic         valid,
   output logic         zero
);

   typedef enum logic [2:0] {
      OP_CLR  = 3'b000,
      OP_SET  = 3'b001,
      OP_GET  = 3'b010,
      OP_LOAD = 3'b011,
      OP_SLL  = 3'b100,
      OP_SRL  = 3'b101,
      OP_SRA  = 3'b110,
      OP_EXT  = 3'b111
   } op_e;

   op_e          op;
   logic [W-1:0] mask;
   logic [6:0]   n_val;
   logic [W-1:0] a;
   logic [5:0]   idx;
   logic         in_range;
   logic         sign;
   logic [W-1:0] onehot;
   logic [W-1:0] sra_fill;
   logic [6:0]   pop_cnt;
   logic [W-1:0] res;

   logic [W-1:0] out_q, out_d;
   logic         valid_q, valid_d;
   logic         zero_q, zero_d;

   assign op     = op_e'(operation);
   assign idx    = opb[5:0];
   assign onehot = W'(1) << idx;

   always_comb begin
      mask  = '1;
      n_val = 7'd64;
      sign  = opa[63];
      case (size_sel)
         2'b00: begin
            mask  = W'(64'h0000_0000_0000_FFFF);
            n_val = 7'd16;
            sign  = opa[15];
         end
         2'b01: begin
            mask  = W'(64'h0000_0000_FFFF_FFFF);
            n_val = 7'd32;
            sign  = opa[31];
         end
         default: ;
      endcase
   end

   assign a        = opa & mask;
   assign in_range = ({1'b0, idx} < n_val);
   // Ones in the top idx bits of the active width: positions vacated by SRA.
   assign sra_fill = ~(mask >> idx) & mask;

   always_comb begin
      pop_cnt = '0;
      for (int unsigned k = 0; k < W; k++) begin
         pop_cnt = pop_cnt + 7'(a[k]);
      end
   end

   always_comb begin
      res = '0;
      case (op)
         OP_CLR:  res = in_range ? (a & ~onehot) : a;
         OP_SET:  res = in_range ? (a | onehot) : a;
         OP_GET:  res = in_range ? W'(a[idx]) : '0;
         OP_LOAD: res = a;
         OP_SLL:  res = in_range ? (a << idx) : '0;
         OP_SRL:  res = in_range ? (a >> idx) : '0;
         OP_SRA: begin
            if (in_range) res = (a >> idx) | (sign ? sra_fill : '0);
            else          res = sign ? mask : '0;
         end
         OP_EXT: begin
`ifdef INT_BIT_MANIP_POPCNT_EN
            res = W'(pop_cnt);
`else
            res = '0;
`endif
         end
         default: res = '0;
      endcase
      // Single point that enforces zero-extension above the active width.
      res = res & mask;
   end

   always_comb begin
      out_d   = out_q;
      zero_d  = zero_q;
      valid_d = 1'b0;
      if (en) begin
         out_d   = res;
         zero_d  = (res == '0);
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         zero_q  <= zero_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign zero  = zero_q;

endmodule

// File: tb/tb_int_bit_manip_core.sv
// tb_int_bit_manip_core
//   Self-checking bench for int_bit_manip_core. A bit-level reference model
//   predicts out/valid/zero every cycle; directed cases pin literal values.
module tb_int_bit_manip_core;

   logic        clk;
   logic        rst;
   logic        en;
   logic [2:0]  operation;
   logic [1:0]  size_sel;
   logic [63:0] opa;
   logic [63:0] opb;
   logic [63:0] out;
   logic        valid;
   logic        zero;

   int errors = 0;
   int checks = 0;
   bit chk_on = 0;

   logic [63:0] exp_out;
   logic        exp_valid;
   logic        exp_zero;

   int_bit_manip_core #(.W(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .operation (operation),
      .size_sel  (size_sel),
      .opa       (opa),
      .opb       (opb),
      .out       (out),
      .valid     (valid),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each result bit derived from the operation's definition.
   function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [1:0] sz,
                                             input logic [63:0] a_in, input logic [63:0] b);
      int n;
      int i;
      logic [63:0] A;
      logic [63:0] r;
      logic        s;
      n = (sz == 2'b00) ? 16 : (sz == 2'b01) ? 32 : 64;
      i = int'(b[5:0]);
      A = '0;
      r = '0;
      for (int j = 0; j < n; j++) A[j] = a_in[j];
      s = A[n-1];
      case (op)
         3'd0: begin r = A; if (i < n) r[i] = 1'b0; end
         3'd1: begin r = A; if (i < n) r[i] = 1'b1; end
         3'd2: r = (i < n) ? {63'b0, A[i]} : '0;
         3'd3: r = A;
         3'd4: for (int j = 0; j < n; j++) r[j] = (j >= i) ? A[j-i] : 1'b0;
         3'd5: for (int j = 0; j < n; j++) r[j] = (j + i < n) ? A[j+i] : 1'b0;
         3'd6: for (int j = 0; j < n; j++) r[j] = (j + i < n) ? A[j+i] : s;
         default: begin
`ifdef INT_BIT_MANIP_POPCNT_EN
            r = 64'($countones(A));
`else
            r = '0;
`endif
         end
      endcase
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_out   <= '0;
         exp_valid <= 1'b0;
         exp_zero  <= 1'b0;
      end else begin
         exp_valid <= en;
         if (en) begin
            exp_out  <= ref_model(operation, size_sel, opa, opb);
            exp_zero <= (ref_model(operation, size_sel, opa, opb) == 64'd0);
         end
      end
   end

   task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%h want=%h", name, got, want);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check64("model_out", out, exp_out);
         check64("model_valid", 64'(valid), 64'(exp_valid));
         check64("model_zero", 64'(zero), 64'(exp_zero));
      end
   end

   task automatic do_op(input logic [2:0] op, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      en = 1'b1; operation = op; size_sel = sz; opa = a; opb = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] pc_exp;
      rst = 1'b1; en = 1'b0; operation = '0; size_sel = '0; opa = '0; opb = '0;
      repeat (2) @(negedge clk);
      check64("reset_out", out, 64'd0);
      check64("reset_valid", 64'(valid), 64'd0);
      check64("reset_zero", 64'(zero), 64'd0);
      rst = 1'b0;
      chk_on = 1'b1;

      do_op(3'b001, 2'b10, 64'd0, 64'd63);
      check64("set63_out", out, 64'h8000_0000_0000_0000);
      check64("set63_valid", 64'(valid), 64'd1);
      do_op(3'b000, 2'b00, '1, 64'd4);
      check64("clr16_b4", out, 64'h0000_0000_0000_FFEF);
      do_op(3'b000, 2'b00, '1, 64'd20);
      check64("clr16_b20", out, 64'h0000_0000_0000_FFFF);
      do_op(3'b110, 2'b01, 64'h8000_0000, 64'd4);
      check64("sra32_4", out, 64'h0000_0000_F800_0000);
      do_op(3'b110, 2'b01, 64'h8000_0000, 64'd40);
      check64("sra32_40", out, 64'h0000_0000_FFFF_FFFF);
      do_op(3'b100, 2'b00, 64'hFFFF_0000_0000_8001, 64'hFFFF_FFFF_FFFF_FFC1);
      check64("sll16_opb_hi_ignored", out, 64'h0000_0000_0000_0002);
      do_op(3'b101, 2'b10, 64'h8000_0000_0000_0000, 64'd63);
      check64("srl64_63", out, 64'd1);
      do_op(3'b010, 2'b00, 64'h0020, 64'd5);
      check64("get_out", out, 64'd1);
      check64("get_zero", 64'(zero), 64'd0);
      @(negedge clk); en = 1'b0;
      @(posedge clk); #1;
      check64("hold_out", out, 64'd1);
      check64("hold_valid", 64'(valid), 64'd0);

      do_op(3'b111, 2'b10, '1, 64'd0);
`ifdef INT_BIT_MANIP_POPCNT_EN
      pc_exp = 64'd64;
`else
      pc_exp = 64'd0;
`endif
      check64("op111_out", out, pc_exp);
      check64("op111_zero", 64'(zero), (pc_exp == 64'd0) ? 64'd1 : 64'd0);
      check64("op111_valid", 64'(valid), 64'd1);

      // Asynchronous reset between edges.
      do_op(3'b011, 2'b10, 64'h1234_5678_9ABC_DEF0, 64'd0);
      #2 rst = 1'b1;
      #1;
      check64("async_rst_out", out, 64'd0);
      check64("async_rst_valid", 64'(valid), 64'd0);
      check64("async_rst_zero", 64'(zero), 64'd0);
      #1 rst = 1'b0;
      do_op(3'b011, 2'b01, 64'hFFFF_FFFF_0000_00A5, 64'd0);
      check64("post_rst_load", out, 64'h0000_0000_0000_00A5);

      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         en        = ($urandom_range(0, 3) != 0);
         operation = 3'($urandom_range(0, 7));
         size_sel  = 2'($urandom_range(0, 3));
         opa       = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) opb = {$urandom, $urandom};
         else opb = 64'($urandom_range(0, 70));
         if ($urandom_range(0, 7) == 0) opa = (opa[0]) ? '1 : '0;
      end
      @(negedge clk); en = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
